// File: rtl/slice_adder_sequencer.sv
// WIDTH-bit add over NSL cycles through one shared SLICE-bit adder; operands in, result out on valid/ready.
// Optional subtract via `SLICE_ADDER_SUB_EN; result valid NSL+1 cycles after accept, held until out_ready.
module slice_adder_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NSL = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  generate
    if (SLICE < 1 || NSL < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("slice_adder_sequencer: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [IW-1:0]    idx;

  // Operand conditioning happens once at accept, so RUN only sees a plain add.
  logic [WIDTH-1:0] b_eff;
  logic             c_init;
`ifdef SLICE_ADDER_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_init     = cin;
`endif

  logic [SLICE:0] s;
  assign s = {1'b0, a_q[idx*SLICE +: SLICE]} + {1'b0, b_q[idx*SLICE +: SLICE]}
             + {{SLICE{1'b0}}, c_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b_eff;
            c_q      <= c_init;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= s[SLICE-1:0];
          c_q <= s[SLICE];
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= s[SLICE];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // in_ready stays low through the exit cycle; no accept overlaps a drain.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Bench for slice_adder_sequencer: directed cases plus random adds against a full-width arithmetic model.
module tb_slice_adder_sequencer;
  localparam int NSL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;

  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2;
  logic [3:0]  a2, b2, sum2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slice_adder_sequencer #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  slice_adder_sequencer #(.WIDTH(4), .SLICE(4)) dut_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned add, or a - b with cout meaning "no borrow".
  function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
    int unsigned r;
    logic [15:0] d;
`ifdef SLICE_ADDER_SUB_EN
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
`endif
    r = 32'(x) + 32'(y) + 32'(ci);
    return r[16:0];
  endfunction

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic s, input int holds,
                       input logic [15:0] es, input logic ec);
    @(negedge clk);
    check("accept_in_ready", in_ready, 1);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Keep offering junk and asserting out_ready while busy: both must be ignored.
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    out_ready = 1'b1;
    for (int k = 1; k <= NSL; k++) begin
      @(negedge clk);
      check("run_out_valid", out_valid, 0);
      check("run_in_ready", in_ready, 0);
    end
    @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("done_sum", sum, es);
    check("done_cout", cout, ec);
    in_valid = 1'b0;
    out_ready = (holds == 0);
    for (int h = 0; h < holds; h++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, es);
      check("hold_cout", cout, ec);
      if (h == holds - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] x, y;
    logic        ci, s;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_narrow_in_ready", in_ready2, 1);
    check("rst_narrow_out_valid", out_valid2, 0);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1);
    do_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 3, 16'hB4B5, 1'b0);

`ifdef SLICE_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1);
`else
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'h000C, 1'b0);
`endif

    // Reset in the second RUN cycle aborts and clears the partial sum.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0);

    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      ci = 1'($urandom);
      s = 1'($urandom);
      r = ref_op(x, y, ci, s);
      do_op(x, y, ci, s, int'($urandom_range(0, 3)), r[15:0], r[16]);
    end

    // Single-slice configuration: one RUN cycle.
    @(negedge clk);
    a2 = 4'h9; b2 = 4'h8; cin2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    a2 = 4'h0; b2 = 4'h0;
    @(negedge clk);
    check("narrow_run_out_valid", out_valid2, 0);
    check("narrow_run_in_ready", in_ready2, 0);
    @(negedge clk);
    check("narrow_done_out_valid", out_valid2, 1);
    check("narrow_sum", sum2, 4'h1);
    check("narrow_cout", cout2, 1);
    out_ready2 = 1'b1;
    @(negedge clk);
    check("narrow_drain_out_valid", out_valid2, 0);
    check("narrow_drain_in_ready", in_ready2, 1);
    out_ready2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
